// File: rtl/switch_allocator_pkg.sv
// Shared router parameters and port encoding used by the switch allocator.
package noc_params;
    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 4;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    // Enum value doubles as the array index of the port.
    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 0,
        NORTH = 1,
        SOUTH = 2,
        WEST  = 3,
        EAST  = 4
    } port_t;
endpackage

// File: rtl/switch_allocator_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the
// granted index only when update_i is asserted.
module round_robin_arbiter #(
    parameter int AGENTS_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] requests_i,
    input  logic                  update_i,
    output logic [AGENTS_NUM-1:0] grants_o
);
    localparam int PW = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

    logic [PW-1:0] ptr_q, ptr_d, nxt_ptr, idx;
    logic          found;

    always_comb begin
        grants_o = '0;
        nxt_ptr  = ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < AGENTS_NUM; k++) begin
            idx = PW'((int'(ptr_q) + k) % AGENTS_NUM);
            if (!found && requests_i[idx]) begin
                found         = 1'b1;
                grants_o[idx] = 1'b1;
                nxt_ptr       = PW'((int'(idx) + 1) % AGENTS_NUM);
            end
        end
    end

    // Kept separate from the grant logic so update_i has no path into grants_o.
    always_comb begin
        ptr_d = update_i ? nxt_ptr : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with registered grants.
// Define SA_ON_OFF_MASK_EN to mask requests toward downstream VCs signalled OFF.
module switch_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM = noc_params::PORT_NUM,
    parameter int VC_NUM   = noc_params::VC_NUM
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]       request_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]       out_port_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]       on_off_i,
    output logic  [PORT_NUM-1:0]                   valid_sel_o,
    output logic  [PORT_NUM-1:0][VC_SIZE-1:0]      vc_sel_o,
    output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]    xbar_sel_o,
    output logic  [PORT_NUM-1:0]                   xbar_valid_o
);
    logic  [PORT_NUM-1:0][VC_NUM-1:0]   elig, s1_gnt;
    logic  [PORT_NUM-1:0]               cand_vld, s1_upd, s2_upd;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]  cand_vc;
    port_t [PORT_NUM-1:0]               cand_op;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_req, s2_gnt;  // [op][ip]

    logic [PORT_NUM-1:0]                valid_sel_d, valid_sel_q, xbar_valid_d, xbar_valid_q;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel_d, vc_sel_q;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel_d, xbar_sel_q;

`ifdef SA_ON_OFF_MASK_EN
    always_comb begin
        elig = '0;
        for (int ip = 0; ip < PORT_NUM; ip++)
            for (int v = 0; v < VC_NUM; v++)
                elig[ip][v] = request_i[ip][v] && (int'(out_port_i[ip][v]) < PORT_NUM) &&
                              on_off_i[out_port_i[ip][v]][downstream_vc_i[ip][v]];
    end
`else
    // Flow control is already folded into request_i upstream.
    logic unused_flow_ctl;
    assign unused_flow_ctl = ^{on_off_i, downstream_vc_i};
    always_comb elig = request_i;
`endif

    always_comb begin
        cand_vld = '0;
        cand_vc  = '0;
        cand_op  = {PORT_NUM{LOCAL}};
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            cand_vld[ip] = |s1_gnt[ip];
            for (int v = 0; v < VC_NUM; v++)
                if (s1_gnt[ip][v]) begin
                    cand_vc[ip] = VC_SIZE'(v);
                    cand_op[ip] = out_port_i[ip][v];
                end
        end
    end

    always_comb begin
        s2_req = '0;
        for (int op = 0; op < PORT_NUM; op++)
            for (int ip = 0; ip < PORT_NUM; ip++)
                s2_req[op][ip] = cand_vld[ip] && (int'(cand_op[ip]) == op);
    end

    always_comb begin
        s2_upd = '0;
        for (int op = 0; op < PORT_NUM; op++) s2_upd[op] = |s2_req[op];
    end

    // A stage-1 pointer only moves when its candidate also won an output.
    always_comb begin
        s1_upd = '0;
        for (int op = 0; op < PORT_NUM; op++) s1_upd = s1_upd | s2_gnt[op];
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
        round_robin_arbiter #(.AGENTS_NUM(VC_NUM)) u_s1 (
            .clk(clk), .rst(rst), .requests_i(elig[g]), .update_i(s1_upd[g]), .grants_o(s1_gnt[g])
        );
        round_robin_arbiter #(.AGENTS_NUM(PORT_NUM)) u_s2 (
            .clk(clk), .rst(rst), .requests_i(s2_req[g]), .update_i(s2_upd[g]), .grants_o(s2_gnt[g])
        );
    end

    always_comb begin
        valid_sel_d  = '0;
        vc_sel_d     = '0;
        xbar_sel_d   = '0;
        xbar_valid_d = '0;
        for (int op = 0; op < PORT_NUM; op++)
            for (int ip = 0; ip < PORT_NUM; ip++)
                if (s2_gnt[op][ip]) begin
                    xbar_valid_d[op] = 1'b1;
                    xbar_sel_d[op]   = PORT_SIZE'(ip);
                    valid_sel_d[ip]  = 1'b1;
                    vc_sel_d[ip]     = cand_vc[ip];
                end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_sel_q  <= '0;
            vc_sel_q     <= '0;
            xbar_sel_q   <= '0;
            xbar_valid_q <= '0;
        end else begin
            valid_sel_q  <= valid_sel_d;
            vc_sel_q     <= vc_sel_d;
            xbar_sel_q   <= xbar_sel_d;
            xbar_valid_q <= xbar_valid_d;
        end
    end

    assign valid_sel_o  = valid_sel_q;
    assign vc_sel_o     = vc_sel_q;
    assign xbar_sel_o   = xbar_sel_q;
    assign xbar_valid_o = xbar_valid_q;
endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic against a
// behavioural two-stage round-robin model.
module tb_switch_allocator;
    import noc_params::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off;
    logic  [PORT_NUM-1:0]                          valid_sel, xbar_valid;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0]           xbar_sel;

    switch_allocator dut (
        .clk(clk), .rst(rst), .request_i(request), .out_port_i(out_port),
        .downstream_vc_i(dvc), .on_off_i(on_off), .valid_sel_o(valid_sel),
        .vc_sel_o(vc_sel), .xbar_sel_o(xbar_sel), .xbar_valid_o(xbar_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int s1p[PORT_NUM];
    int s2p[PORT_NUM];
    logic [PORT_NUM-1:0]                e_valid, e_xval;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   e_vc;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] e_xsel;
    bit started = 0;

    function automatic bit eligible(int ip, int v);
`ifdef SA_ON_OFF_MASK_EN
        int op = int'(out_port[ip][v]);
        if (op >= PORT_NUM) return 0;
        return request[ip][v] && on_off[op][dvc[ip][v]];
`else
        return request[ip][v];
`endif
    endfunction

    task automatic model_step();
        int cand[PORT_NUM];
        e_valid = '0; e_xval = '0; e_vc = '0; e_xsel = '0;
        if (rst) begin
            for (int i = 0; i < PORT_NUM; i++) begin s1p[i] = 0; s2p[i] = 0; end
            return;
        end
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            cand[ip] = -1;
            for (int k = 0; k < VC_NUM; k++) begin
                int v = (s1p[ip] + k) % VC_NUM;
                if (eligible(ip, v)) begin cand[ip] = v; break; end
            end
        end
        for (int op = 0; op < PORT_NUM; op++) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                int ip = (s2p[op] + k) % PORT_NUM;
                if (cand[ip] >= 0 && int'(out_port[ip][cand[ip]]) == op) begin
                    e_xval[op]  = 1'b1;
                    e_xsel[op]  = PORT_SIZE'(ip);
                    e_valid[ip] = 1'b1;
                    e_vc[ip]    = VC_SIZE'(cand[ip]);
                    s2p[op] = (ip + 1) % PORT_NUM;
                    s1p[ip] = (cand[ip] + 1) % VC_NUM;
                    break;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        started = 1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("valid_sel", 64'(valid_sel), 64'(e_valid));
            chk("vc_sel", 64'(vc_sel), 64'(e_vc));
            chk("xbar_sel", 64'(xbar_sel), 64'(e_xsel));
            chk("xbar_valid", 64'(xbar_valid), 64'(e_xval));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        request = '0;
        dvc     = '0;
        on_off  = '1;
        for (int i = 0; i < PORT_NUM; i++)
            for (int v = 0; v < VC_NUM; v++) out_port[i][v] = LOCAL;
    endtask

    task automatic set_req(input int ip, input int v, input port_t op, input int d);
        request[ip][v]  = 1'b1;
        out_port[ip][v] = op;
        dvc[ip][v]      = VC_SIZE'(d);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        chk("reset_valid_sel", 64'(valid_sel), 64'd0);
        chk("reset_xbar_valid", 64'(xbar_valid), 64'd0);
        rst = 1'b0;
    endtask

    logic [PORT_NUM-1:0][VC_SIZE-1:0]   x_vc;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] x_xs;

    initial begin
        clear_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step(); step();
        chk("idle_valid_sel", 64'(valid_sel), 64'd0);
        chk("idle_xbar", 64'({xbar_valid, xbar_sel, vc_sel}), 64'd0);

        // single request
        do_reset();
        set_req(1, 2, EAST, 0);
        step();
        x_vc = '0; x_vc[1] = 2'(2);
        x_xs = '0; x_xs[4] = 3'(1);
        chk("single_valid_sel", 64'(valid_sel), 64'(5'b00010));
        chk("single_vc_sel", 64'(vc_sel), 64'(x_vc));
        chk("single_xbar_sel", 64'(xbar_sel), 64'(x_xs));
        chk("single_xbar_valid", 64'(xbar_valid), 64'(5'b10000));
        chk("model_single_xsel", 64'(e_xsel), 64'(x_xs));
        chk("model_single_vc", 64'(e_vc), 64'(x_vc));
        clear_inputs();
        step();
        chk("single_drained", 64'(xbar_valid), 64'd0);

        // output contention: inputs 0,1,2 -> LOCAL
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 0, LOCAL, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("contend_xbar_sel", 64'(xbar_sel[0]), 64'(c % 3));
            chk("contend_valid_sel", 64'(valid_sel), 64'(1 << (c % 3)));
            chk("model_contend", 64'(e_xsel[0]), 64'(c % 3));
        end
        // reset mid-stream then restart from index 0
        rst = 1'b1;
        step();
        chk("midrst_outputs", 64'({valid_sel, xbar_valid}), 64'd0);
        rst = 1'b0;
        step();
        chk("midrst_restart", 64'(xbar_sel[0]), 64'd0);
        chk("midrst_restart_v", 64'(valid_sel), 64'(5'b00001));

        // stage-1 fairness: input 3, VCs 0..3 -> outputs 0..3
        do_reset();
        for (int v = 0; v < VC_NUM; v++) set_req(3, v, port_t'(v), 0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("fair_vc_sel", 64'(vc_sel[3]), 64'(c % VC_NUM));
            chk("fair_xbar_sel", 64'(xbar_sel[c % VC_NUM]), 64'd3);
        end

        // starvation guard: input 0 VC1 loses NORTH once, then must retry VC1
        do_reset();
        set_req(1, 0, NORTH, 0);
        step();
        chk("starve_warm", 64'(xbar_sel[1]), 64'd1);
        set_req(2, 0, NORTH, 0);
        set_req(0, 1, NORTH, 0);
        set_req(0, 2, SOUTH, 0);
        step();
        chk("starve_lose", 64'(xbar_sel[1]), 64'd2);
        chk("starve_lose_v", 64'(valid_sel[0]), 64'd0);
        step();
        chk("starve_win", 64'(xbar_sel[1]), 64'd0);
        chk("starve_win_vc", 64'(vc_sel[0]), 64'd1);
        chk("starve_south_idle", 64'(xbar_valid[2]), 64'd0);

        // on/off handling
        do_reset();
`ifdef SA_ON_OFF_MASK_EN
        on_off[4][1] = 1'b0;
        set_req(1, 2, EAST, 1);
        set_req(1, 3, WEST, 0);
        step();
        chk("onoff_alt_vc", 64'(vc_sel[1]), 64'd3);
        chk("onoff_alt_xv", 64'(xbar_valid), 64'(5'b01000));
        request[1][3] = 1'b0;
        step();
        chk("onoff_blocked", 64'(xbar_valid), 64'd0);
        on_off[4][1] = 1'b1;
        step();
        chk("onoff_resume", 64'(xbar_valid), 64'(5'b10000));
        chk("onoff_resume_vc", 64'(vc_sel[1]), 64'd2);
`else
        on_off[4][1] = 1'b0;
        set_req(1, 2, EAST, 1);
        step();
        chk("onoff_ignored", 64'(xbar_valid), 64'(5'b10000));
        chk("onoff_ignored_vc", 64'(vc_sel[1]), 64'd2);
`endif

        // random traffic, occasional mid-stream reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < PORT_NUM; i++)
                for (int v = 0; v < VC_NUM; v++) begin
                    request[i][v]  = ($urandom_range(0, 1) == 1);
                    out_port[i][v] = port_t'($urandom_range(0, PORT_NUM - 1));
                    dvc[i][v]      = VC_SIZE'($urandom_range(0, VC_NUM - 1));
                    on_off[i][v]   = ($urandom_range(0, 3) != 0);
                end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        clear_inputs();
        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Separable input-first switch allocator for the mesh router, placed directly downstream of the per-port `input_port` instances. Each cycle it picks at most one buffered VC per input port and at most one input port per output port. It drives back `valid_sel_i`/`vc_sel_i` into each `input_port` so the head-of-queue flit is read, and drives the crossbar select for the same cycle. Requests toward downstream VCs that are signalled OFF are suppressed.

## Interface
Parameters:
- `PORT_NUM`, default 5: router ports (LOCAL, NORTH, SOUTH, WEST, EAST).
- `VC_NUM`, default from `noc_params`: virtual channels per port.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `request_i` input, [PORT_NUM][VC_NUM]: input VC has a flit ready with VA completed. Producer already accounts for a grant currently on `valid_sel_o`.
- `out_port_i` input, [PORT_NUM][VC_NUM] `port_t`: output port routed for each input VC.
- `downstream_vc_i` input, [PORT_NUM][VC_NUM] × VC_SIZE: downstream VC assigned by VA.
- `on_off_i` input, [PORT_NUM][VC_NUM]: per output port, per downstream VC. 1 = may send.
- `valid_sel_o` output, [PORT_NUM]: read strobe to `input_port`.
- `vc_sel_o` output, [PORT_NUM] × VC_SIZE: VC to read.
- `xbar_sel_o` output, [PORT_NUM] × PORT_SIZE: indexed by output port; value is the winning input port.
- `xbar_valid_o` output, [PORT_NUM]: crossbar output carries a flit.

## Operation
- **Eligibility.** Input VC (ip,v) is eligible when `request_i[ip][v]` is 1 (plus the on/off check under Configuration).
- **Stage 1, per input port.**
  - A VC_NUM-way round-robin arbiter picks one eligible VC.
  - This produces a candidate (ip, v, out_port).
- **Stage 2, per output port.**
  - A PORT_NUM-way round-robin arbiter picks among input ports whose stage-1 candidate targets that output.
  - An input port may target its own port index; U-turns are not filtered here.
- **Round-robin rule.**
  - The pointer holds the highest-priority index.
  - Search order is pointer, pointer+1, …, wrapping modulo N.
  - After granting index g, pointer ← (g+1) mod N. Wrap from N-1 goes to 0.
- **Pointer update.**
  - A stage-2 pointer updates only when that arbiter grants.
  - A stage-1 pointer updates only when its candidate also wins stage 2. A losing candidate keeps its priority, which prevents starvation.
- **Grant outputs.** For each stage-2 grant (op ← ip, VC v), the next state is:
  - `valid_sel_o[ip]`=1, `vc_sel_o[ip]`=v
  - `xbar_sel_o[op]`=ip, `xbar_valid_o[op]`=1
- **Output invariants.**
  - At most one `valid_sel_o` per input port.
  - At most one `xbar_valid_o` source per output.
  - Each input port appears in at most one `xbar_sel_o`.
- **Unused fields.** Non-granted fields (`vc_sel_o`, `xbar_sel_o`) are driven 0.
- **No requests.** All valid outputs are 0 and the pointers hold.

## Timing
- **Reset.**
  - Every output is 0.
  - All arbiter pointers are 0 (index 0 has highest priority).
  - Reset asserted mid-operation discards any pending grant at the next edge, and pointers return to 0.
- **Latency.**
  - Inputs sampled at edge t produce registered grants visible during cycle t+1.
  - `input_port` reads on that cycle, and the crossbar uses the same-cycle select.
- **Throughput.**
  - One grant per input port and one per output port every cycle.
  - Back-to-back grants to the same VC are allowed while `request_i` stays high.
- **Simultaneous events.**
  - A request and an `on_off_i` drop in the same cycle: the sampled OFF wins and no grant is issued.
  - Pointer update and grant occur at the same edge.

## Configuration
- **`SA_ON_OFF_MASK_EN` defined.**
  - Eligibility additionally requires `on_off_i[out_port_i[ip][v]][downstream_vc_i[ip][v]]`=1.
  - OFF VCs never win, so another VC of the same input can win instead.
- **Not defined.**
  - `on_off_i` is ignored. Flow control is enforced upstream by masking `request_i`.
  - Grants depend only on `request_i`/`out_port_i`.

## Structure
- **`noc_params`** holds `PORT_NUM`, `VC_NUM`, `VC_SIZE`, `port_t`, plus a new `PORT_SIZE` = $clog2(PORT_NUM).
- **`port_t` encoding.** The enum encodes directly as the port index used for the arrays.
- **Sub-module `round_robin_arbiter`.**
  - Parameter `AGENTS_NUM`.
  - Ports: `clk`, `rst`, `requests_i`, `update_i`, `grants_o` (one-hot, combinational).
  - It holds the pointer internally.
- **Instances.** PORT_NUM stage-1 instances and PORT_NUM stage-2 instances.
- **Top level.** Output registers and the request/eligibility muxing live in `switch_allocator`.

## Test plan
- **Reset.** Reset, then all requests 0 → all outputs 0 every cycle.
- **Single request.** Single request (ip=1, v=2, op=EAST) at t → during t+1: `valid_sel_o[1]`=1, `vc_sel_o[1]`=2, `xbar_sel_o[EAST]`=1, `xbar_valid_o[EAST]`=1. Other outputs 0.
- **Output contention.** Inputs 0,1,2 all request op=LOCAL continuously → grants rotate 0,1,2,0,…, one per cycle. `valid_sel_o` matches the granted input.
- **Stage-1 fairness.** One input with VCs 0..3 all requesting different free outputs → VC grants cycle 0,1,2,3,0 (wrap).
- **Starvation guard.** Input 0 VC1 loses stage 2 repeatedly → its stage-1 pointer stays on VC1 until it wins, within PORT_NUM cycles.
- **On/off and reset.** With `SA_ON_OFF_MASK_EN`: target downstream VC OFF → no grant. OFF→ON → grant the next cycle. `rst` asserted mid-stream → outputs 0 the next cycle and arbitration restarts from index 0.
